// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and types for the binary-to-BCD display path.
// Holds digit counts, the largest displayable decimal value, the
// saturated display pattern and the converter FSM states.
package display_pkg;

    localparam int DIGITS     = 8;
    localparam int INT_DIGITS = 9;

    localparam logic [26:0] MAX_DEC = 27'd99_999_999;
    localparam logic [31:0] SAT_BCD = 32'h9999_9999;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle between a binary producer and bin_to_bcd_seq.
// The master side offers a value with valid_in and observes the result;
// the slave side is the converter itself.
interface bin_to_bcd_seq_if
    import display_pkg::*;
#(
    parameter int BIN_W = 27
);

    logic                  valid_in;
    logic [BIN_W-1:0]      bin_in;
    logic                  ready_out;
    logic                  valid_out;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf_out;

    modport master (
        output valid_in,
        output bin_in,
        input  ready_out,
        input  valid_out,
        input  bcd_out,
        input  ovf_out
    );

    modport slave (
        input  valid_in,
        input  bin_in,
        output ready_out,
        output valid_out,
        output bcd_out,
        output ovf_out
    );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Single double-dabble correction cell: a BCD digit of 5 or more gets 3
// added so that the following left shift carries correctly into the
// next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Add-3 correction applied before every shift
    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Accepts a value on valid_in && ready_out, iterates BIN_W times and then
// pulses valid_out for one cycle with eight packed BCD digits on bcd_out.
// bcd_out only changes on that pulse, so the display never sees partial
// results.
// Optional feature macro BCD_SAT_EN: values above 99_999_999 saturate to
// 9999_9999 and raise ovf_out. Without it the result is the value mod 10^8
// and ovf_out is tied low.
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int BIN_W = 27
) (
    input  logic              clk_in,
    input  logic              rst_in,
    bin_to_bcd_seq_if.slave   bus
);

    localparam int SR_W  = 4 * INT_DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    state_t              state;
    state_t              state_next;
    logic [SR_W-1:0]     sreg;
    logic [SR_W-1:0]     sreg_adj;
    logic [SR_W-1:0]     sreg_next;
    logic [CNT_W-1:0]    iter;
    logic                accept;
    logic                last_iter;
    logic                finish;
    logic [4*DIGITS-1:0] result;
    logic                unused_msb;

    assign bus.ready_out = (state == IDLE);
    assign accept        = bus.valid_in && (state == IDLE);
    assign last_iter     = (iter == LAST_ITER);
    assign finish        = (state == SHIFT) && last_iter;

    // Correct every internal digit, leave the not-yet-shifted binary bits alone
    genvar g;
    generate
        for (g = 0; g < INT_DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (sreg[BIN_W + 4*g +: 4]),
                .adjusted (sreg_adj[BIN_W + 4*g +: 4])
            );
        end
    endgenerate

    assign sreg_adj[BIN_W-1:0] = sreg[BIN_W-1:0];
    assign sreg_next           = {sreg_adj[SR_W-2:0], 1'b0};
    assign unused_msb          = sreg_adj[SR_W-1];

`ifdef BCD_SAT_EN
    logic ovf_pend;
    logic ovf_now;

    assign ovf_now = 32'(bus.bin_in) > 32'(MAX_DEC);
    assign result  = ovf_pend ? SAT_BCD : sreg_next[BIN_W +: 4*DIGITS];

    // Remember at accept time whether the value is out of range; publish it with the result
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ovf_pend    <= 1'b0;
            bus.ovf_out <= 1'b0;
        end else begin
            if (accept) begin
                ovf_pend <= ovf_now;
            end
            if (finish) begin
                bus.ovf_out <= ovf_pend;
            end
        end
    end
`else
    assign result      = sreg_next[BIN_W +: 4*DIGITS];
    assign bus.ovf_out = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave IDLE on accept, return after the last iteration
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = SHIFT;
            SHIFT:   if (last_iter) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift register, iteration counter and registered result outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sreg          <= '0;
            iter          <= '0;
            bus.valid_out <= 1'b0;
            bus.bcd_out   <= '0;
        end else begin
            bus.valid_out <= 1'b0;
            if (accept) begin
                sreg <= SR_W'(bus.bin_in);
                iter <= '0;
            end else if (state == SHIFT) begin
                sreg <= sreg_next;
                iter <= iter + CNT_W'(1);
                if (last_iter) begin
                    bus.bcd_out   <= result;
                    bus.valid_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq. Expected results come from a
// decimal-division model and are queued at accept time; a monitor pops and
// compares them on every valid_out pulse.
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 27;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int pulses = 0;
    int accepts = 0;
    int lastPulseCycle = 0;
    int lastAcceptCycle = 0;

    logic [32:0] sbQueue[$];

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    // Free-running cycle counter used to measure latency and accept spacing
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: split into decimal digits by repeated division
    function automatic logic [32:0] bcdModel(input longint value);
        longint v;
        logic [32:0] r;
        r = '0;
`ifdef BCD_SAT_EN
        if (value > 64'd99999999) begin
            return {1'b1, 32'h9999_9999};
        end
`endif
        v = value % 100000000;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Scoreboard: every result pulse must match the oldest queued expectation
    always @(negedge clk) begin : monitorResult
        logic [32:0] expVal;
        if (!rst && bus.valid_out) begin
            pulses++;
            lastPulseCycle = cycle;
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_valid", 1, 0);
            end else begin
                expVal = sbQueue.pop_front();
                checkOutput("bcd_out", bus.bcd_out, expVal[31:0]);
                checkOutput("ovf_out", bus.ovf_out, expVal[32]);
            end
        end
    end

    // Accept tracker: a handshake seen now completes on the next rising edge
    always @(negedge clk) begin
        if (!rst && bus.valid_in && bus.ready_out) begin
            accepts++;
            lastAcceptCycle = cycle + 1;
        end
    end

    task automatic waitReady();
        int n = 0;
        while (!bus.ready_out && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.ready_out) checkOutput("ready_timeout", 0, 1);
    endtask

    task automatic waitPulses(input int target);
        int n = 0;
        while (pulses < target && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (pulses < target) checkOutput("result_timeout", pulses, target);
    endtask

    task automatic applyStimulus(input logic [BIN_W-1:0] value, input bit expectResult, output int acceptCycle);
        waitReady();
        bus.valid_in = 1'b1;
        bus.bin_in   = value;
        @(posedge clk);
        #1;
        acceptCycle = cycle;
        if (expectResult) sbQueue.push_back(bcdModel(value));
        bus.valid_in = 1'b0;
    endtask

    task automatic convert(input logic [BIN_W-1:0] value);
        int acceptCycle;
        int p;
        p = pulses;
        applyStimulus(value, 1'b1, acceptCycle);
        checkOutput("ready_busy", bus.ready_out, 0);
        waitPulses(p + 1);
        checkOutput("latency", lastPulseCycle - acceptCycle, BIN_W);
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        int a0;
        int a1;
        int p0;
        int acc0;

        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.bin_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", bus.ready_out, 1);
        checkOutput("rst_valid", bus.valid_out, 0);
        checkOutput("rst_bcd", bus.bcd_out, 0);
        checkOutput("rst_ovf", bus.ovf_out, 0);
        rst = 1'b0;

        convert(27'd0);
        convert(27'd12_345_678);
        convert(27'd99_999_999);
        convert(27'd100_000_123);

        // Back-to-back with valid_in held high; bin_in changes mid-conversion
        waitReady();
        p0   = pulses;
        acc0 = accepts;
        bus.valid_in = 1'b1;
        bus.bin_in   = 27'd42;
        sbQueue.push_back(bcdModel(42));
        @(posedge clk);
        #1;
        a0 = cycle;
        repeat (10) @(posedge clk);
        #1;
        bus.bin_in = 27'd7;
        sbQueue.push_back(bcdModel(7));
        waitPulses(p0 + 1);
        a1 = lastAcceptCycle;
        bus.valid_in = 1'b0;
        checkOutput("accept_count", accepts - acc0, 2);
        checkOutput("accept_gap", a1 - a0, BIN_W + 1);
        waitPulses(p0 + 2);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("pulse_count", pulses - p0, 2);

        // Reset during the tenth iteration of a conversion of 555
        applyStimulus(27'd555, 1'b0, a0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_valid", bus.valid_out, 0);
        checkOutput("abort_ready", bus.ready_out, 1);
        checkOutput("abort_bcd", bus.bcd_out, 0);
        checkOutput("abort_ovf", bus.ovf_out, 0);
        rst = 1'b0;
        p0 = pulses;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("abort_no_pulse", pulses, p0);
        convert(27'd555);

        checkOutput("sb_empty", sbQueue.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
